nn_argmax_decoder: RTL and testbench

- Consumer end of the classifier's score interface: latches the NUM_CLASSES signed 256-bit class scores produced by the dense output layer.
- Scans the latched scores sequentially, one per cycle, to find the winning class (argmax).
- Compares the winning score against a programmable threshold.
- Presents class index, winning score and a recognised flag to downstream control through a valid/ready handshake.

---
 rtl/nn_argmax_decoder.sv | 114 +++++++++++
 tb/tb_nn_argmax_decoder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_argmax_decoder.sv
// nn_argmax_decoder
// Latches the class scores from the dense output layer, scans them one per
// cycle to find the winning class, compares the winner against a programmable
// threshold and hands the result downstream over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start_i; scores and threshold are sampled on accept
// SCAN  | comparing bank[k] against the running best, one class per cycle
// DONE  | publishing the result (first cycle), then holding until accepted
module nn_argmax_decoder #(
    parameter int NUM_CLASSES = 8,
    parameter int SCORE_W     = 256,
    parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start_i,
    input  logic [NUM_CLASSES-1:0][SCORE_W-1:0]   scores_i,
    input  logic signed [SCORE_W-1:0]             threshold_i,
    output logic                                  busy_o,
    output logic                                  result_valid_o,
    input  logic                                  result_ready_i,
    output logic [IDX_W-1:0]                      class_idx_o,
    output logic signed [SCORE_W-1:0]             best_score_o,
    output logic                                  recognised_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                               state;
    logic [NUM_CLASSES-1:0][SCORE_W-1:0]  bank;
    logic signed [SCORE_W-1:0]            thr;
    logic signed [SCORE_W-1:0]            best;
    logic [IDX_W-1:0]                     best_idx;
    logic [IDX_W-1:0]                     k;
    logic signed [SCORE_W-1:0]            cand;

    // Select the bank entry under the scan pointer; the explicit mux keeps the
    // index width independent of NUM_CLASSES (including the single-class build).
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (k == IDX_W'(i)) begin
                cand = $signed(bank[i]);
            end
        end
    end

    // Decode sequencer: sample, scan, publish, then wait for the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bank           <= '0;
            thr            <= '0;
            best           <= '0;
            best_idx       <= '0;
            k              <= '0;
            busy_o         <= 1'b0;
            result_valid_o <= 1'b0;
            class_idx_o    <= '0;
            best_score_o   <= '0;
            recognised_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        bank     <= scores_i;
                        thr      <= threshold_i;
                        best     <= $signed(scores_i[0]);
                        best_idx <= '0;
                        k        <= IDX_W'(1);
                        busy_o   <= 1'b1;
                        state    <= (NUM_CLASSES > 1) ? SCAN : DONE;
                    end
                end
                SCAN: begin
                    // strictly greater only, so ties keep the lower index
                    if (cand > best) begin
                        best     <= cand;
                        best_idx <= k;
                    end
                    k <= k + 1'b1;
                    if (k == LAST_IDX) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!result_valid_o) begin
                        // first DONE cycle: register the result for downstream
                        result_valid_o <= 1'b1;
                        class_idx_o    <= best_idx;
                        best_score_o   <= best;
                        recognised_o   <= (best >= thr);
                    end else if (result_ready_i) begin
                        // result fields keep their values until the next decode
                        result_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_argmax_decoder.sv
// Bench for nn_argmax_decoder: an 8-class instance checked every cycle against
// a cycle-count/argmax model, plus a single-class instance checked directly.
module tb_nn_argmax_decoder;

    localparam int N  = 8;
    localparam int W  = 256;
    localparam int IW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              start;
    logic [N-1:0][W-1:0] scores;
    logic [W-1:0]      thr;
    logic              ready;
    logic              busy, valid;
    logic [IW-1:0]     idx;
    logic [W-1:0]      score;
    logic              rec;

    logic              start1;
    logic [0:0][W-1:0] scores1;
    logic [W-1:0]      thr1;
    logic              ready1;
    logic              busy1, valid1;
    logic [0:0]        idx1;
    logic [W-1:0]      score1;
    logic              rec1;

    nn_argmax_decoder #(.NUM_CLASSES(N), .SCORE_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .scores_i(scores),
        .threshold_i(thr), .busy_o(busy), .result_valid_o(valid),
        .result_ready_i(ready), .class_idx_o(idx), .best_score_o(score),
        .recognised_o(rec)
    );

    nn_argmax_decoder #(.NUM_CLASSES(1), .SCORE_W(W)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .scores_i(scores1),
        .threshold_i(thr1), .busy_o(busy1), .result_valid_o(valid1),
        .result_ready_i(ready1), .class_idx_o(idx1), .best_score_o(score1),
        .recognised_o(rec1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sx(input int v);
        sx = {{(W-32){v[31]}}, v};
    endfunction

    function automatic logic [N-1:0][W-1:0] mk(input int v0, input int v1, input int v2, input int v3,
                                              input int v4, input int v5, input int v6, input int v7);
        mk[0] = sx(v0); mk[1] = sx(v1); mk[2] = sx(v2); mk[3] = sx(v3);
        mk[4] = sx(v4); mk[5] = sx(v5); mk[6] = sx(v6); mk[7] = sx(v7);
    endfunction

    // Reference argmax: first index holding the maximum signed value.
    function automatic void argmax(input logic [N-1:0][W-1:0] s, input logic [W-1:0] t,
                                   output int bi, output logic [W-1:0] bs, output logic r);
        bi = 0;
        bs = s[0];
        for (int i = 1; i < N; i++) begin
            if ($signed(s[i]) > $signed(bs)) begin
                bi = i;
                bs = s[i];
            end
        end
        r = ($signed(bs) >= $signed(t));
    endfunction

    // Model: a decode takes N cycles from its accepting edge to a valid result.
    logic         m_busy = 1'b0;
    logic         m_valid = 1'b0;
    int           m_cd = 0;
    logic [IW-1:0] m_idx = '0;
    logic [W-1:0] m_score = '0;
    logic         m_rec = 1'b0;
    int           p_idx = 0;
    logic [W-1:0] p_score = '0;
    logic         p_rec = 1'b0;
    logic         cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_cd = 0;
            m_idx = '0; m_score = '0; m_rec = 1'b0;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
        end else if (!m_busy && start) begin
            argmax(scores, thr, p_idx, p_score, p_rec);
            m_busy = 1'b1;
            m_cd   = N;
        end else if (m_busy && !m_valid) begin
            m_cd--;
            if (m_cd == 0) begin
                m_valid = 1'b1;
                m_idx   = p_idx[IW-1:0];
                m_score = p_score;
                m_rec   = p_rec;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy",  W'(busy),  W'(m_busy));
            check("cyc_valid", W'(valid), W'(m_valid));
            check("cyc_idx",   W'(idx),   W'(m_idx));
            check("cyc_score", score,     m_score);
            check("cyc_rec",   W'(rec),   W'(m_rec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_decode(input logic [N-1:0][W-1:0] s, input logic [W-1:0] t);
        scores = s;
        thr    = t;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        check(name, W'(n), W'(exp_lat));
    endtask

    task automatic expect_res(input string tag, input int e_idx, input logic [W-1:0] e_score, input logic e_rec);
        check({tag, "_valid"}, W'(valid), W'(1'b1));
        check({tag, "_idx"},   W'(idx),   W'(e_idx));
        check({tag, "_score"}, score,     e_score);
        check({tag, "_rec"},   W'(rec),   W'(e_rec));
    endtask

    logic [N-1:0][W-1:0] s_ext;
    logic [W-1:0]        max_pos;
    logic [W-1:0]        min_neg;

    initial begin
        rst_n = 1'b0; start = 1'b0; ready = 1'b0; scores = '0; thr = '0;
        start1 = 1'b0; ready1 = 1'b0; scores1 = '0; thr1 = '0;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_busy",  W'(busy),  W'(1'b0));
        check("rst_valid", W'(valid), W'(1'b0));
        check("rst_idx",   W'(idx),   W'(0));
        check("rst_score", score,     W'(0));
        check("rst_rec",   W'(rec),   W'(1'b0));
        rst_n = 1'b1;
        tick();

        // basic argmax, downstream always ready
        ready = 1'b1;
        start_decode(mk(5, -3, 100, 7, 99, 0, -200, 12), sx(50));
        wait_valid("basic_latency", 8);
        expect_res("basic", 2, sx(100), 1'b1);
        tick();
        check("basic_valid_drop", W'(valid), W'(1'b0));

        // negative scores with a tie between 5 and 6
        start_decode(mk(-10, -10, -10, -10, -10, -4, -4, -10), sx(0));
        wait_valid("tie_latency", 8);
        expect_res("tie", 5, sx(-4), 1'b0);
        tick();

        // all equal: lowest index wins, equality with threshold recognised
        start_decode(mk(3, 3, 3, 3, 3, 3, 3, 3), sx(3));
        wait_valid("eq_latency", 8);
        expect_res("eq", 0, sx(3), 1'b1);
        tick();

        // full-width extremes
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};
        s_ext = '0;
        s_ext[7] = max_pos;
        s_ext[0] = min_neg;
        start_decode(s_ext, max_pos);
        wait_valid("ext_latency", 8);
        expect_res("ext", 7, max_pos, 1'b1);
        tick();

        // bit 200 must beat bit 199
        s_ext = '0;
        s_ext[1][200] = 1'b1;
        s_ext[6][199] = 1'b1;
        start_decode(s_ext, sx(0));
        wait_valid("wide_latency", 8);
        expect_res("wide", 1, s_ext[1], 1'b1);
        tick();

        // backpressure with start pulses and input changes during SCAN/DONE
        ready = 1'b0;
        start_decode(mk(5, -3, 100, 7, 99, 0, -200, 12), sx(50));
        begin
            int n = 0;
            while (!valid && n < 40) begin
                start  = ~start;
                scores = mk(900, 901, 902, 903, 904, 905, 906, 907 + n);
                thr    = sx(1000);
                tick();
                n++;
            end
            check("bp_latency", W'(n), W'(8));
        end
        for (int c = 0; c < 20; c++) begin
            start  = c[0];
            scores = mk(-1, -1, -1, -1, -1, -1, -1, c);
            tick();
            expect_res("bp_hold", 2, sx(100), 1'b1);
        end
        scores = mk(1, 2, 3, 4, 50, 6, 7, 8);
        thr    = sx(51);
        ready  = 1'b1;
        start  = 1'b1;
        tick();
        check("hs_valid_drop",   W'(valid), W'(1'b0));
        check("hs_start_ignored", W'(busy), W'(1'b0));
        tick();
        start = 1'b0;
        check("next_start_busy", W'(busy), W'(1'b1));
        wait_valid("next_latency", 8);
        expect_res("next", 4, sx(50), 1'b0);
        tick();

        // reset during the third SCAN cycle
        start_decode(mk(5, -3, 100, 7, 99, 0, -200, 12), sx(50));
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",  W'(busy),  W'(1'b0));
        check("mid_rst_valid", W'(valid), W'(1'b0));
        check("mid_rst_idx",   W'(idx),   W'(0));
        check("mid_rst_score", score,     W'(0));
        check("mid_rst_rec",   W'(rec),   W'(1'b0));
        tick();
        rst_n = 1'b1;
        tick();
        start_decode(mk(-50, -60, -7, -8, -70, -9, -100, -7), sx(-7));
        wait_valid("post_rst_latency", 8);
        expect_res("post_rst", 2, sx(-7), 1'b1);
        tick();

        // single-class build
        scores1[0] = sx(-77);
        thr1       = sx(-76);
        start1     = 1'b1;
        tick();
        start1 = 1'b0;
        check("n1_busy",      W'(busy1),  W'(1'b1));
        check("n1_not_yet",   W'(valid1), W'(1'b0));
        scores1[0] = sx(5);
        tick();
        check("n1_valid",     W'(valid1), W'(1'b1));
        check("n1_idx",       W'(idx1),   W'(0));
        check("n1_score",     score1,     sx(-77));
        check("n1_rec",       W'(rec1),   W'(1'b0));
        ready1 = 1'b1;
        tick();
        check("n1_valid_drop", W'(valid1), W'(1'b0));
        check("n1_score_hold", score1,     sx(-77));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
